// File: rtl/sync_fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side schedulers.
package fifo_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } arb_state_t;

   function automatic int id_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/sync_fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO push port shared by the write arbiter.
interface sync_fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32
);
   import fifo_arb_pkg::*;

   localparam int ID_W = id_w(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_push;
   logic [ID_W+WIDTH-1:0]         fifo_data;
   logic                          grant_valid;
   logic [ID_W-1:0]               grant_id;
   logic                          stall;

   // Arbiter side.
   modport slave (
      input  req_valid, req_data, fifo_full,
      output req_ready, fifo_push, fifo_data, grant_valid, grant_id, stall
   );

   // Producers, FIFO and observers.
   modport master (
      output req_valid, req_data, fifo_full,
      input  req_ready, fifo_push, fifo_data, grant_valid, grant_id, stall
   );

endinterface

// File: rtl/sync_fifo_wr_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          req,
   input  logic [id_w(NUM_REQ)-1:0]    ptr,
   output logic                        any,
   output logic [id_w(NUM_REQ)-1:0]    idx
);

   localparam int ID_W = id_w(NUM_REQ);

   logic [ID_W-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest hit is the last write.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (req[cand]) begin
            any = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin burst scheduler sharing one sync_fifo push port between NUM_REQ producers.
//   state | meaning
//   ARB   | no grant; pick next valid producer at or after rr_ptr
//   HOLD  | grant held; push granted words until burst done or valid drops
module sync_fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   sync_fifo_wr_arbiter_if.slave bus
);

   localparam int ID_W    = id_w(NUM_REQ);
   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("sync_fifo_wr_arbiter: NUM_REQ must be at least 2");
   end
   if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("sync_fifo_wr_arbiter: MAX_BURST must be at least 1");
   end

   arb_state_t         state_q, state_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               grant_valid_q, grant_valid_d;

   logic               pick_any;
   logic [ID_W-1:0]    pick_idx;
   logic               cur_valid;
   logic               push;
   logic [NUM_REQ-1:0] ready;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign cur_valid = bus.req_valid[grant_id_q];
   assign push      = grant_valid_q && cur_valid && !bus.fifo_full && !flush;

   always_comb begin
      ready = '0;
      if (grant_valid_q && !bus.fifo_full && !flush) begin
         ready[grant_id_q] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         ARB: begin
            if (pick_any) begin
               state_d     = HOLD;
               grant_id_d  = pick_idx;
               burst_cnt_d = '0;
            end
         end
         HOLD: begin
            // A dropped valid releases even while the FIFO is full.
            if (!cur_valid || (push && burst_cnt_q == BURST_LAST)) begin
               state_d  = ARB;
               rr_ptr_d = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
            end else if (push) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
      if (flush) begin
         state_d     = ARB;
         grant_id_d  = '0;
         rr_ptr_d    = '0;
         burst_cnt_d = '0;
      end
      grant_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARB;
         grant_id_q    <= '0;
         rr_ptr_q      <= '0;
         burst_cnt_q   <= '0;
         grant_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_id_q    <= grant_id_d;
         rr_ptr_q      <= rr_ptr_d;
         burst_cnt_q   <= burst_cnt_d;
         grant_valid_q <= grant_valid_d;
      end
   end

   assign bus.req_ready   = ready;
   assign bus.fifo_push   = push;
   assign bus.fifo_data   = {grant_id_q, bus.req_data[grant_id_q]};
   assign bus.grant_valid = grant_valid_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.stall       = grant_valid_q && cur_valid && bus.fifo_full;

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Randomized bench for sync_fifo_wr_arbiter against a transaction-level grant model and a FIFO queue.
module tb_sync_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int W     = 32;
   localparam int MB    = 4;
   localparam int IDW   = 2;
   localparam int DEPTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   always #5 clk = ~clk;

   sync_fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

   sync_fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // grant model: who holds the grant, pushes so far, next search start
   bit m_hold;
   int m_gid, m_cnt, m_ptr;

   // producers
   logic [N-1:0] pv;
   logic [W-1:0] pdata [N];
   int           seq [N];
   bit           acc [N];
   logic [N-1:0] mask;
   int           limit, vpct, full_pct, flush_pct;
   bit           drop_en, fifo_en, force_flush;

   // downstream FIFO model
   logic [IDW+W-1:0] q [$];
   int               exp_seq [N];
   int               dut_np;

   function automatic logic [IDW-1:0] ix(input int i);
      return IDW'(i);
   endfunction

   function automatic int rnd100();
      return int'($urandom_range(0, 99));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hold = 1'b0;
      m_gid  = 0;
      m_cnt  = 0;
      m_ptr  = 0;
   endtask

   task automatic pop_one();
      logic [IDW+W-1:0] w;
      int               t;
      logic [W-1:0]     e;
      w = q.pop_front();
      t = int'(w[IDW+W-1:W]);
      e = (W'(t) << 24) | W'(exp_seq[ix(t)]);
      chk("pop_order", w[W-1:0], e);
      exp_seq[ix(t)]++;
   endtask

   task automatic step();
      bit           full_in, fl, e_push, e_stall;
      logic [N-1:0] e_ready;
      int           pick, c;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (acc[ix(i)]) begin
            seq[ix(i)]++;
            pv[ix(i)] = 1'b0;
         end
         if (!pv[ix(i)]) begin
            if (mask[ix(i)] && seq[ix(i)] < limit && rnd100() < vpct) pv[ix(i)] = 1'b1;
         end else if (drop_en && $urandom_range(0, 15) == 0) begin
            pv[ix(i)] = 1'b0;
         end
         pdata[ix(i)] = (W'(i) << 24) | W'(seq[ix(i)]);
      end
      full_in = (fifo_en && q.size() >= DEPTH) || (rnd100() < full_pct);
      fl      = force_flush || (rnd100() < flush_pct);
      bus.req_valid = pv;
      for (int i = 0; i < N; i++) bus.req_data[ix(i)] = pdata[ix(i)];
      bus.fifo_full = full_in;
      flush         = fl;
      #1;
      e_push  = m_hold && pv[ix(m_gid)] && !full_in && !fl;
      e_stall = m_hold && pv[ix(m_gid)] && full_in;
      e_ready = '0;
      if (m_hold && !full_in && !fl) e_ready[ix(m_gid)] = 1'b1;
      chk("grant_valid", bus.grant_valid, m_hold);
      chk("grant_id", bus.grant_id, ix(m_gid));
      chk("fifo_push", bus.fifo_push, e_push);
      chk("req_ready", bus.req_ready, e_ready);
      chk("stall", bus.stall, e_stall);
      if (e_push) chk("fifo_data", bus.fifo_data, {ix(m_gid), pdata[ix(m_gid)]});
      if (bus.fifo_push) dut_np++;
      for (int i = 0; i < N; i++) acc[ix(i)] = pv[ix(i)] && e_ready[ix(i)];
      if (fifo_en && bus.fifo_push) begin
         chk("overflow", q.size() >= DEPTH, 1'b0);
         q.push_back(bus.fifo_data);
      end
      if (fifo_en && q.size() > 0 && rnd100() < 40) pop_one();
      // advance the grant model by one clock
      if (fl) begin
         model_reset();
      end else if (!m_hold) begin
         pick = -1;
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (pick < 0 && pv[ix(c)]) pick = c;
         end
         if (pick >= 0) begin
            m_hold = 1'b1;
            m_gid  = pick;
            m_cnt  = 0;
         end
      end else if (!pv[ix(m_gid)] || (e_push && m_cnt + 1 == MB)) begin
         m_hold = 1'b0;
         m_ptr  = (m_gid + 1) % N;
      end else if (e_push) begin
         m_cnt++;
      end
   endtask

   task automatic do_async_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_grant_valid", bus.grant_valid, 1'b0);
      chk("rst_fifo_push", bus.fifo_push, 1'b0);
      chk("rst_req_ready", bus.req_ready, '0);
      chk("rst_stall", bus.stall, 1'b0);
      chk("rst_grant_id", bus.grant_id, '0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      pv = '0;
      for (int i = 0; i < N; i++) begin
         seq[ix(i)]   = 0;
         acc[ix(i)]   = 1'b0;
         pdata[ix(i)] = '0;
      end
      mask = '0; limit = 0; vpct = 0; full_pct = 0; flush_pct = 0;
      drop_en = 1'b0; fifo_en = 1'b0; force_flush = 1'b0; dut_np = 0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_data[0] = 32'h00A5_0000;
      bus.fifo_full = 1'b0;
      #12 rst_n = 1'b1;
      #1;
      chk("reset_grant_valid", bus.grant_valid, 1'b0);
      chk("reset_fifo_push", bus.fifo_push, 1'b0);
      chk("reset_stall", bus.stall, 1'b0);
      chk("reset_req_ready", bus.req_ready, '0);
      chk("reset_grant_id", bus.grant_id, '0);
      chk("reset_fifo_data", bus.fifo_data, {2'b00, 32'h00A5_0000});

      // single producer 2, six words, no backpressure
      mask = 4'b0100; limit = 6; vpct = 100; dut_np = 0;
      repeat (12) step();
      chk("single_pushes", dut_np, 6);

      // all producers busy: 20 pushes in 25 cycles
      do_async_reset();
      mask = 4'b1111; limit = 1000000; dut_np = 0;
      repeat (25) step();
      chk("rr_pushes", dut_np, 20);

      // flush while a grant is held
      step();
      step();
      chk("pre_flush_gv", bus.grant_valid, 1'b1);
      force_flush = 1'b1;
      step();
      force_flush = 1'b0;
      step();
      chk("flush_gv", bus.grant_valid, 1'b0);

      // randomized run into an 8-deep FIFO
      do_async_reset();
      q.delete();
      for (int i = 0; i < N; i++) exp_seq[ix(i)] = seq[ix(i)] + (acc[ix(i)] ? 1 : 0);
      fifo_en = 1'b1; vpct = 60; drop_en = 1'b1; full_pct = 10; flush_pct = 1;
      for (int c = 0; c < 3000; c++) begin
         step();
         if (c % 700 == 350) do_async_reset();
      end
      while (q.size() > 0) pop_one();
      for (int i = 0; i < N; i++) chk("no_loss", exp_seq[ix(i)], seq[ix(i)] + (acc[ix(i)] ? 1 : 0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
